// File: rtl/fft_result_reader.sv
// Drains a completed FFT frame from the ping-pong butterfly memory as a natural-order stream.
// Build option BITREV_EN: memory holds bit-reversed (DIT) order; otherwise natural order.
module fft_result_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] addr_A_read,
  output logic [ADDR_WIDTH-1:0] addr_B_read,
  input  logic [DATA_WIDTH-1:0] A_real_in,
  input  logic [DATA_WIDTH-1:0] A_imag_in,
  input  logic [DATA_WIDTH-1:0] B_real_in,
  input  logic [DATA_WIDTH-1:0] B_imag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_CAPT  = 3'd2,
    S_EMIT0 = 3'd3,
    S_EMIT1 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   k, k_nxt, k1;
  logic                    load_addr;
  logic [CW-1:0]           wait_cnt;
  logic [DATA_WIDTH-1:0]   hold0_re, hold0_im, hold1_re, hold1_im;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_b_q;

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] x);
    logic [ADDR_WIDTH-1:0] r;
`ifdef BITREV_EN
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = x[ADDR_WIDTH-1-i];
`else
    r = x;
`endif
    return r;
  endfunction

  assign k1 = k + ADDR_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    load_addr = 1'b0;
    k_nxt     = k;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ADDR;
          load_addr = 1'b1;
          k_nxt     = '0;
        end
      end
      S_ADDR:  if (wait_cnt == WAIT_LAST) state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_EMIT0;
      S_EMIT0: if (out_ready) state_nxt = S_EMIT1;
      S_EMIT1: begin
        if (out_ready) begin
          load_addr = 1'b1;
          k_nxt     = k + ADDR_WIDTH'(2);
          // k1 all-ones means the pair just accepted carried index N-1
          state_nxt = (&k1) ? S_DONE : S_ADDR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      k        <= '0;
      wait_cnt <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      hold0_re <= '0;
      hold0_im <= '0;
      hold1_re <= '0;
      hold1_im <= '0;
    end else begin
      state <= state_nxt;
      // Addresses only move between pairs, so a stalled output never re-reads memory
      if (load_addr) begin
        k        <= k_nxt;
        addr_a_q <= map_addr(k_nxt);
        addr_b_q <= map_addr(k_nxt + ADDR_WIDTH'(1));
      end
      if (state == S_ADDR) wait_cnt <= wait_cnt + CW'(1);
      else                 wait_cnt <= '0;
      if (state == S_CAPT) begin
        hold0_re <= A_real_in;
        hold0_im <= A_imag_in;
        hold1_re <= B_real_in;
        hold1_im <= B_imag_in;
      end
    end
  end

  // Valid/ready: a beat transfers on a rising edge with out_valid && out_ready; while
  // out_valid is high and out_ready low, every output field holds and out_valid stays high.
  always_comb begin
    out_valid = (state == S_EMIT0) || (state == S_EMIT1);
    out_real  = '0;
    out_imag  = '0;
    out_index = '0;
    if (state == S_EMIT0) begin
      out_real  = hold0_re;
      out_imag  = hold0_im;
      out_index = k;
    end else if (state == S_EMIT1) begin
      out_real  = hold1_re;
      out_imag  = hold1_im;
      out_index = k1;
    end
    out_last = out_valid && (&out_index);
  end

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign addr_A_read = addr_a_q;
  assign addr_B_read = addr_b_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: RD_LATENCY=1 and RD_LATENCY=3 instances fed by
// memory models where mem[a].re = a and mem[a].im = ~a.
module tb_fft_result_reader;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // RD_LATENCY = 1 instance
  logic          start = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] addr_a, addr_b, addr_a_q, addr_b_q;
  logic [DW-1:0] a_re, a_im, b_re, b_im, out_real, out_imag;
  logic [AW-1:0] out_index;
  logic          out_valid, out_last, busy, done;
  logic [2:0]    dbg_state;

  // RD_LATENCY = 3 instance
  logic          start3 = 1'b0, ready3 = 1'b1;
  logic [AW-1:0] addr_a3, addr_b3;
  logic [AW-1:0] a3p [3];
  logic [AW-1:0] b3p [3];
  logic [DW-1:0] a3_re, a3_im, b3_re, b3_im, out_real3, out_imag3;
  logic [AW-1:0] out_index3;
  logic          out_valid3, out_last3, busy3, done3;
  logic [2:0]    dbg_state3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_re(input logic [AW-1:0] a);
    return DW'(a);
  endfunction

  function automatic logic [DW-1:0] mem_im(input logic [AW-1:0] a);
    return ~(DW'(a));
  endfunction

  function automatic logic [AW-1:0] exp_map(input logic [AW-1:0] x);
    logic [AW-1:0] r;
`ifdef BITREV_EN
    for (int i = 0; i < AW; i++) r[i] = x[AW-1-i];
`else
    r = x;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    addr_a_q <= addr_a;
    addr_b_q <= addr_b;
    a3p[0] <= addr_a3; a3p[1] <= a3p[0]; a3p[2] <= a3p[1];
    b3p[0] <= addr_b3; b3p[1] <= b3p[0]; b3p[2] <= b3p[1];
  end

  assign a_re  = mem_re(addr_a_q);
  assign a_im  = mem_im(addr_a_q);
  assign b_re  = mem_re(addr_b_q);
  assign b_im  = mem_im(addr_b_q);
  assign a3_re = mem_re(a3p[2]);
  assign a3_im = mem_im(a3p[2]);
  assign b3_re = mem_re(b3p[2]);
  assign b3_im = mem_im(b3p[2]);

  fft_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addr_A_read(addr_a), .addr_B_read(addr_b),
    .A_real_in(a_re), .A_imag_in(a_im), .B_real_in(b_re), .B_imag_in(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  fft_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3),
    .addr_A_read(addr_a3), .addr_B_read(addr_b3),
    .A_real_in(a3_re), .A_imag_in(a3_im), .B_real_in(b3_re), .B_imag_in(b3_im),
    .out_valid(out_valid3), .out_ready(ready3),
    .out_real(out_real3), .out_imag(out_imag3), .out_index(out_index3), .out_last(out_last3),
    .busy(busy3), .done(done3), .dbg_state(dbg_state3)
  );

  task automatic test_reset;
    bit found, seen;
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, busy, done, out_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {out_valid, busy, done, out_last});
    end
    checks++;
    if (addr_a !== '0 || addr_b !== '0 || out_real !== '0 || out_index !== '0) begin
      errors++;
      $display("FAIL reset_data: addr_a=%0d addr_b=%0d real=%0d index=%0d expected all 0",
               addr_a, addr_b, out_real, out_index);
    end
    rst_n = 1'b1;
    @(negedge clk);
    // Start a frame and stall it in EMIT0, then reset mid-frame
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_reach_emit0: out_valid got 0 expected 1 within 20 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done} !== 3'b000 || addr_a !== '0 || addr_b !== '0) begin
      errors++;
      $display("FAIL reset_async: valid/busy/done=%b addr_a=%0d addr_b=%0d expected 000,0,0",
               {out_valid, busy, done}, addr_a, addr_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: activity after reset got %b expected 0", seen);
    end
  endtask

  task automatic test_full_drain;
    int t, beat, first_t, last_t, done_t;
    out_ready = 1'b1;
    start = 1'b1;
    t = 0; beat = 0; first_t = 0; last_t = 0; done_t = 0;
    while (t < 300 && done_t == 0) begin
      @(negedge clk);
      start = 1'b0;
      t++;
      if (out_valid) begin
        if (beat == 0) first_t = t;
        checks++;
        if (out_index !== AW'(beat)) begin
          errors++;
          $display("FAIL drain_index: got %0d expected %0d", out_index, beat);
        end
        checks++;
        if (out_real !== mem_re(exp_map(AW'(beat))) || out_imag !== mem_im(exp_map(AW'(beat)))) begin
          errors++;
          $display("FAIL drain_data k=%0d: got %h/%h expected %h/%h", beat, out_real, out_imag,
                   mem_re(exp_map(AW'(beat))), mem_im(exp_map(AW'(beat))));
        end
        checks++;
        if (out_last !== (beat == N - 1)) begin
          errors++;
          $display("FAIL drain_last k=%0d: got %b expected %b", beat, out_last, beat == N - 1);
        end
        if (beat % 2 == 0) begin
          checks++;
          if (addr_a !== exp_map(AW'(beat)) || addr_b !== exp_map(AW'(beat + 1))) begin
            errors++;
            $display("FAIL drain_addr k=%0d: got %0d/%0d expected %0d/%0d", beat, addr_a, addr_b,
                     exp_map(AW'(beat)), exp_map(AW'(beat + 1)));
          end
        end
        if (out_last) last_t = t;
        beat++;
      end
      if (done) done_t = t;
    end
    checks++;
    if (beat != N) begin
      errors++;
      $display("FAIL drain_beats: got %0d expected %0d", beat, N);
    end
    checks++;
    if (first_t != 3) begin
      errors++;
      $display("FAIL drain_first_valid: got %0d expected 3", first_t);
    end
    checks++;
    if (last_t != 64) begin
      errors++;
      $display("FAIL drain_last_beat_time: got %0d expected 64", last_t);
    end
    checks++;
    if (done_t != 65) begin
      errors++;
      $display("FAIL drain_done_time: got %0d expected 65", done_t);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL drain_idle: done/busy got %b expected 00", {done, busy});
    end
  endtask

  task automatic test_backpressure;
    bit found, got_done;
    logic [AW-1:0] sa, sb;
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_index == AW'(6)) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL bp_reach_k6: not seen within 100 cycles, expected index 6");
    end
    out_ready = 1'b0;
    sa = addr_a;
    sb = addr_b;
    checks++;
    if (sa !== exp_map(AW'(6)) || sb !== exp_map(AW'(7))) begin
      errors++;
      $display("FAIL bp_addr: got %0d/%0d expected %0d/%0d", sa, sb, exp_map(AW'(6)), exp_map(AW'(7)));
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_index !== AW'(6) || out_real !== mem_re(exp_map(AW'(6)))) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b index=%0d real=%0d expected 1,6,%0d", i,
                 out_valid, out_index, out_real, mem_re(exp_map(AW'(6))));
      end
      checks++;
      if (addr_a !== sa || addr_b !== sb) begin
        errors++;
        $display("FAIL bp_addr_stable cycle %0d: got %0d/%0d expected %0d/%0d", i, addr_a, addr_b, sa, sb);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_index !== AW'(7) || out_real !== mem_re(exp_map(AW'(7)))) begin
      errors++;
      $display("FAIL bp_next: valid=%b index=%0d real=%0d expected 1,7,%0d",
               out_valid, out_index, out_real, mem_re(exp_map(AW'(7))));
    end
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL bp_done: done got 0 expected 1 within 200 cycles");
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int beats, dones;
    out_ready = 1'b1;
    start = 1'b1;
    beats = 0;
    dones = 0;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) beats++;
      if (done) dones++;
      // cycle 1 is ADDR, cycle 4 is EMIT1, cycle 65 is DONE
      if (t == 1 || t == 4 || t == 65) start = 1'b1;
    end
    checks++;
    if (beats != N) begin
      errors++;
      $display("FAIL start_ign_beats: got %0d expected %0d", beats, N);
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL start_ign_done_count: got %0d expected 1", dones);
    end
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL start_ign_idle: busy/valid got %b expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_rd_latency3;
    int t, beat, first_t, last_t, done_t;
    start3 = 1'b1;
    t = 0; beat = 0; first_t = 0; last_t = 0; done_t = 0;
    while (t < 300 && done_t == 0) begin
      @(negedge clk);
      start3 = 1'b0;
      t++;
      if (out_valid3) begin
        if (beat == 0) first_t = t;
        checks++;
        if (out_index3 !== AW'(beat) || out_real3 !== mem_re(exp_map(AW'(beat))) ||
            out_imag3 !== mem_im(exp_map(AW'(beat))) || out_last3 !== (beat == N - 1)) begin
          errors++;
          $display("FAIL lat3_beat k=%0d: index=%0d real=%h imag=%h last=%b expected %0d %h %h %b",
                   beat, out_index3, out_real3, out_imag3, out_last3, beat,
                   mem_re(exp_map(AW'(beat))), mem_im(exp_map(AW'(beat))), beat == N - 1);
        end
        if (out_last3) last_t = t;
        beat++;
      end
      if (done3) done_t = t;
    end
    checks++;
    if (first_t != 5) begin
      errors++;
      $display("FAIL lat3_first_valid: got %0d expected 5", first_t);
    end
    checks++;
    if (beat != N || last_t != 96 || done_t != 97) begin
      errors++;
      $display("FAIL lat3_frame: beats=%0d last_t=%0d done_t=%0d expected 32 96 97",
               beat, last_t, done_t);
    end
  endtask

  initial begin
    test_reset();
    test_full_drain();
    test_backpressure();
    test_start_ignored();
    test_rd_latency3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule
